// File: rtl/param_adder.sv
// Ripple-carry adder with carry-in.
// Subtractions are built by feeding the inverted operand with cin=1.
module param_adder #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             cin,
    output logic [Width-1:0] sum
);

    logic carry;

    // Bit-serial ripple: each bit's carry feeds the next; the final carry-out is not needed.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int k = 0; k < Width; k++) begin
            sum[k] = a[k] ^ b[k] ^ carry;
            carry  = (a[k] & b[k]) | (carry & (a[k] ^ b[k]));
        end
    end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotation engine: rotates (x, y) by a 16-bit binary angle, one
// micro-rotation per clock, with a valid/ready handshake on both sides.
// Optional macro CORDIC_GAIN_COMP_EN adds a COMP cycle that scales the result by 1/K.
// ITER must lie in 1..15 (the arctangent table has 15 entries).
module cordic_rotator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic [15:0]             angle_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH+1:0] x_out,
    output logic signed [WIDTH+1:0] y_out
);

    localparam int unsigned XW = WIDTH + 2;

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {StIdle, StRotate, StComp, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;
`endif

    state_e                state_q;
    logic signed [XW-1:0]  x_q, y_q;
    logic [15:0]           z_q;
    logic [3:0]            iter_q;

    // round(atan(2^-i) * 2^16 / 2pi)
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd8192;
            4'd1:    return 16'd4836;
            4'd2:    return 16'd2555;
            4'd3:    return 16'd1297;
            4'd4:    return 16'd651;
            4'd5:    return 16'd326;
            4'd6:    return 16'd163;
            4'd7:    return 16'd81;
            4'd8:    return 16'd41;
            4'd9:    return 16'd20;
            4'd10:   return 16'd10;
            4'd11:   return 16'd5;
            4'd12:   return 16'd3;
            4'd13:   return 16'd1;
            4'd14:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // v * (2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13) ~= v / 1.6468, each shift truncated.
    function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
    endfunction
`endif

    // Load path with quadrant pre-rotation: angles in [90deg, 270deg) are folded by
    // negating the vector and adding 180deg, keeping the residual within CORDIC range.
    logic                 swap;
    logic signed [XW-1:0] x_ext, y_ext, x_ld, y_ld;
    logic [15:0]          z_ld;

    assign swap  = angle_in[15] ^ angle_in[14];
    assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};
    assign x_ld  = swap ? -x_ext : x_ext;
    assign y_ld  = swap ? -y_ext : y_ext;
    assign z_ld  = swap ? {~angle_in[15], angle_in[14:0]} : angle_in;

    // Micro-rotation datapath. d_pos selects d=+1 (Z non-negative).
    logic                 d_pos, last_iter;
    logic signed [XW-1:0] x_sh, y_sh, x_op, y_op, x_nxt, y_nxt;
    logic [15:0]          atan_i, z_op, z_nxt;

    assign d_pos     = ~z_q[15];
    assign last_iter = (iter_q == 4'(ITER - 1));
    assign x_sh      = x_q >>> iter_q;
    assign y_sh      = y_q >>> iter_q;
    assign atan_i    = atan_lut(iter_q);
    // X - d*(Y>>>i), Y + d*(X>>>i), Z - d*atan[i]; subtraction = invert + carry-in.
    assign x_op      = d_pos ? ~y_sh : y_sh;
    assign y_op      = d_pos ? x_sh : ~x_sh;
    assign z_op      = d_pos ? ~atan_i : atan_i;

    param_adder #(.Width(XW)) u_x_add (
        .a   (x_q),
        .b   (x_op),
        .cin (d_pos),
        .sum (x_nxt)
    );

    param_adder #(.Width(XW)) u_y_add (
        .a   (y_q),
        .b   (y_op),
        .cin (~d_pos),
        .sum (y_nxt)
    );

    param_adder #(.Width(16)) u_z_add (
        .a   (z_q),
        .b   (z_op),
        .cin (d_pos),
        .sum (z_nxt)
    );

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW-1:0] x_cmp, y_cmp;
    assign x_cmp = gain_comp(x_q);
    assign y_cmp = gain_comp(y_q);
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    // Control FSM, working registers and the registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            x_out   <= '0;
            y_out   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q     <= x_ld;
                        y_q     <= y_ld;
                        z_q     <= z_ld;
                        iter_q  <= '0;
                        state_q <= StRotate;
                    end
                end
                StRotate: begin
                    x_q    <= x_nxt;
                    y_q    <= y_nxt;
                    z_q    <= z_nxt;
                    iter_q <= iter_q + 4'd1;
                    if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_q <= StComp;
`else
                        x_out   <= x_nxt;
                        y_out   <= y_nxt;
                        state_q <= StDone;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                StComp: begin
                    x_q     <= x_cmp;
                    y_q     <= y_cmp;
                    x_out   <= x_cmp;
                    y_out   <= y_cmp;
                    state_q <= StDone;
                end
`endif
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
